// File: rtl/pcm_lane_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcm_lane_feeder                                              |
// | Description : Paces a valid/ready PCM stream into one FIR lane's buffer    |
// |               write port with a minimum spacing between writes. Pulses the |
// |               lane start strobe every N-th write and captures the lane     |
// |               output on each start as a one-cycle result strobe.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pcm_lane_feeder #(
  parameter int pcmaw = 8,
  parameter int dsw   = 8
) (
  input  logic              pcm_clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data,
  input  logic [dsw-1:0]    cfg_downsample,
  input  logic [11:0]       cfg_min_gap,
  output logic              pcm_in_wr,
  output logic [15:0]       pcm_in,
  output logic [pcmaw-1:0]  pcm_in_address,
  output logic              fir_start,
  input  logic [15:0]       pcm_out,
  output logic              res_valid,
  output logic [15:0]       res_data
);

  localparam logic [11:0] c_gcnt_max = 12'hFFF;

  logic [11:0]      gcnt_q, gcnt_d;
  logic [pcmaw-1:0] wptr_q, wptr_d;
  logic [dsw-1:0]   dcnt_q, dcnt_d;
  logic             primed_q, primed_d;
  logic             pcm_in_wr_q, pcm_in_wr_d;
  logic [15:0]      pcm_in_q, pcm_in_d;
  logic [pcmaw-1:0] pcm_in_address_q, pcm_in_address_d;
  logic             fir_start_q, fir_start_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_data_q, res_data_d;

  logic [11:0]      g_eff;
  logic [dsw-1:0]   n_eff;
  logic             gap_ok;
  logic             accept;
  logic             dec_hit;

  // Effective config (0 behaves as 1), pacing gate and handshake; the compares
  // are one bit wider so neither the gap count nor the decimation count wraps.
  always_comb begin
    g_eff   = (cfg_min_gap == '0) ? 12'd1 : cfg_min_gap;
    n_eff   = (cfg_downsample == '0) ? dsw'(1) : cfg_downsample;
    gap_ok  = ({1'b0, gcnt_q} + 13'd1) >= {1'b0, g_eff};
    s_ready = rst_n & ~clear & gap_ok;
    accept  = s_valid & s_ready;
    dec_hit = ({1'b0, dcnt_q} + (dsw + 1)'(1)) >= {1'b0, n_eff};
  end

  // Next-state: write registration, pointer/decimation/gap counters, result
  // capture; clear overrides the counters but lets in-flight strobes finish.
  always_comb begin
    gcnt_d           = gcnt_q;
    wptr_d           = wptr_q;
    dcnt_d           = dcnt_q;
    primed_d         = primed_q;
    pcm_in_wr_d      = accept;
    fir_start_d      = accept & dec_hit;
    pcm_in_d         = pcm_in_q;
    pcm_in_address_d = pcm_in_address_q;
    res_valid_d      = 1'b0;
    res_data_d       = res_data_q;

    if (accept) begin
      pcm_in_d         = s_data;
      pcm_in_address_d = wptr_q;
      wptr_d           = wptr_q + pcmaw'(1);
      dcnt_d           = dec_hit ? '0 : dcnt_q + dsw'(1);
      gcnt_d           = '0;
    end else if (gcnt_q != c_gcnt_max) begin
      gcnt_d = gcnt_q + 12'd1;
    end

    // The first start after reset/clear sees a stale lane output, so it only arms.
    if (fir_start_q) begin
      if (primed_q) begin
        res_valid_d = 1'b1;
        res_data_d  = pcm_out;
      end
      primed_d = 1'b1;
    end

    if (clear) begin
      wptr_d   = '0;
      dcnt_d   = '0;
      primed_d = 1'b0;
      gcnt_d   = c_gcnt_max;
    end
  end

  // State register with asynchronous reset; gap count resets saturated so the
  // first sample after reset is accepted immediately.
  always_ff @(posedge pcm_clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q           <= c_gcnt_max;
      wptr_q           <= '0;
      dcnt_q           <= '0;
      primed_q         <= 1'b0;
      pcm_in_wr_q      <= 1'b0;
      pcm_in_q         <= '0;
      pcm_in_address_q <= '0;
      fir_start_q      <= 1'b0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
    end else begin
      gcnt_q           <= gcnt_d;
      wptr_q           <= wptr_d;
      dcnt_q           <= dcnt_d;
      primed_q         <= primed_d;
      pcm_in_wr_q      <= pcm_in_wr_d;
      pcm_in_q         <= pcm_in_d;
      pcm_in_address_q <= pcm_in_address_d;
      fir_start_q      <= fir_start_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
    end
  end

  assign pcm_in_wr      = pcm_in_wr_q;
  assign pcm_in         = pcm_in_q;
  assign pcm_in_address = pcm_in_address_q;
  assign fir_start      = fir_start_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_lane_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pcm_lane_feeder                                           |
// | Description : Scoreboard bench: the driver predicts writes and results     |
// |               into queues, a negedge monitor pops them as the DUT emits.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pcm_lane_feeder;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    logic        fs;
  } wr_t;

  logic        pcm_clk = 1'b0;
  logic        rst_n, clear, s_valid, s_ready;
  logic [15:0] s_data, pcm_in, pcm_out, res_data;
  logic [7:0]  cfg_downsample, pcm_in_address;
  logic [11:0] cfg_min_gap;
  logic        pcm_in_wr, fir_start, res_valid;

  pcm_lane_feeder #(.pcmaw(8), .dsw(8)) dut (
    .pcm_clk        (pcm_clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .cfg_downsample (cfg_downsample),
    .cfg_min_gap    (cfg_min_gap),
    .pcm_in_wr      (pcm_in_wr),
    .pcm_in         (pcm_in),
    .pcm_in_address (pcm_in_address),
    .fir_start      (fir_start),
    .pcm_out        (pcm_out),
    .res_valid      (res_valid),
    .res_data       (res_data)
  );

  always #5 pcm_clk = ~pcm_clk;

  int n_chk  = 0;
  int n_pass = 0;

  wr_t         wq[$];
  logic [15:0] rq[$];

  // Reference model state
  int  mg, wptr, dcnt, cyc;
  bit  primed, pend;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic logic [15:0] pat(int c);
    return 16'hC35A ^ 16'(c * 613);
  endfunction

  task automatic model_reset();
    mg = 4095; wptr = 0; dcnt = 0; primed = 0; pend = 0;
    wq.delete(); rq.delete();
  endtask

  // One clock: predict ready/accept at negedge, push expectations, then advance.
  task automatic cycle(output bit acc);
    bit ready, fire;
    int geff, neff;
    wr_t e;
    @(negedge pcm_clk);
    geff = (cfg_min_gap == 0) ? 1 : int'(cfg_min_gap);
    neff = (cfg_downsample == 0) ? 1 : int'(cfg_downsample);
    if (pend) begin
      if (primed) rq.push_back(pcm_out);
      primed = 1;
      pend = 0;
    end
    ready = !clear && (mg + 1 >= geff);
    chk("s_ready", s_ready, ready);
    acc = s_valid && ready;
    if (clear) begin
      wptr = 0; dcnt = 0; primed = 0; mg = 4095;
    end else if (acc) begin
      fire = (dcnt + 1 >= neff);
      e.a = wptr[7:0]; e.d = s_data; e.fs = fire;
      wq.push_back(e);
      wptr = (wptr + 1) % 256;
      dcnt = fire ? 0 : dcnt + 1;
      mg = 0;
      pend = fire;
    end else if (mg < 4095) begin
      mg++;
    end
    @(posedge pcm_clk);
    #1;
    cyc++;
    pcm_out = pat(cyc);
  endtask

  task automatic send(input logic [15:0] d, output int n);
    bit acc;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 5000);
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(acc);
  endtask

  task automatic check_reset_outputs();
    chk("rst_wr",      pcm_in_wr,      0);
    chk("rst_pcm_in",  pcm_in,         0);
    chk("rst_addr",    pcm_in_address, 0);
    chk("rst_start",   fir_start,      0);
    chk("rst_rvalid",  res_valid,      0);
    chk("rst_rdata",   res_data,       0);
    chk("rst_s_ready", s_ready,        0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a result.
  int mon_cyc = 0;
  int last_wr = -1;
  always @(negedge pcm_clk) begin
    wr_t e;
    int  g;
    if (rst_n) begin
      g = (cfg_min_gap == 0) ? 1 : int'(cfg_min_gap);
      if (pcm_in_wr) begin
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected: got write addr %0h data %0h expected none", pcm_in_address, pcm_in);
        end else begin
          e = wq.pop_front();
          chk("wr_addr",  pcm_in_address, e.a);
          chk("wr_data",  pcm_in,         e.d);
          chk("wr_start", fir_start,      e.fs);
        end
        if (last_wr >= 0) chk("wr_spacing_ok", (mon_cyc - last_wr) >= g, 1);
        last_wr = mon_cyc;
      end else if (fir_start) begin
        n_chk++;
        $display("FAIL start_alone: got fir_start=1 expected 0 without pcm_in_wr");
      end
      if (res_valid) begin
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL res_unexpected: got result %0h expected none", res_data);
        end else begin
          chk("res_data", res_data, rq.pop_front());
        end
      end
      if (clear) last_wr = -1;
    end else begin
      last_wr = -1;
    end
    mon_cyc++;
  end

  initial begin
    int n;
    bit acc;
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_min_gap = 12'd7; cfg_downsample = 8'd1;
    cyc = 0; pcm_out = pat(0);
    model_reset();

    // Reset values, then first sample accepted in the very first cycle
    repeat (3) @(posedge pcm_clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    send(16'd0, n);
    chk("first_accept_cycles", n, 1);

    // Pacing G=7, N=1, data 0..4
    for (int i = 1; i < 5; i++) begin
      send(16'(i), n);
      chk("pace_wait_cycles", n, 7);
    end
    idle(10);

    // Decimation G=5, N=2, then lower N while dcnt=1
    cfg_min_gap = 12'd5; cfg_downsample = 8'd2;
    for (int i = 0; i < 10; i++) send(16'h0100 + 16'(i), n);
    send(16'h01AA, n);
    cfg_downsample = 8'd1;
    send(16'h01BB, n);
    idle(8);

    // Clear mid-stream with N=3: held sample blocked during clear
    cfg_min_gap = 12'd2; cfg_downsample = 8'd3;
    clear = 1'b1; cycle(acc); clear = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i), n);
    s_valid = 1'b1; s_data = 16'h3333;
    clear = 1'b1; cycle(acc); clear = 1'b0;
    send(16'h3333, n);
    chk("post_clear_accept_cycles", n, 1);
    send(16'h3334, n);
    send(16'h3335, n);
    idle(20);

    // Idle source saturates the gap count: late sample goes immediately
    cfg_min_gap = 12'd3; cfg_downsample = 8'd4;
    send(16'h5555, n);
    chk("late_accept_cycles", n, 1);

    // Backpressure with holes in s_valid
    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 3));
      send(16'h4000 + 16'(i), n);
    end
    idle(6);

    // Address wrap with G=0 and N=0 (both behave as 1)
    clear = 1'b1; cycle(acc); clear = 1'b0;
    cfg_min_gap = 12'd0; cfg_downsample = 8'd0;
    for (int i = 0; i < 258; i++) begin
      send(16'h8000 + 16'(i), n);
      if (i > 0) chk("back_to_back_cycles", n, 1);
    end
    idle(4);

    // Asynchronous reset with a write, start and result in flight
    cfg_min_gap = 12'd1; cfg_downsample = 8'd1;
    send(16'h9001, n);
    send(16'h9002, n);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge pcm_clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    send(16'h9003, n);
    chk("after_reset_accept_cycles", n, 1);
    send(16'h9004, n);
    idle(6);

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
